// File: rtl/synthesijer_fconv_i2f_arbiter.sv
// synthesijer_fconv_i2f_arbiter: shares one int->float converter core among NUM_REQ requesters.
// Latency: ip_nd one cycle after a grant; res_valid one cycle after the core's ip_valid.
// Backpressure: req_ready is withheld while MAX_INFLIGHT conversions are outstanding.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req_a / req_nd        per-port 32-bit signed operand and request strobe
//   req_ready             one-hot grant (combinational); transfer = req_nd[i] & req_ready[i]
//   res_data / res_valid  shared float result and one-hot owner strobe
//   ip_a / ip_nd          registered operand issue towards the converter core
//   ip_result / ip_valid  converter core result (fixed latency, no backpressure)
//   inflight              number of outstanding conversions
//   err                   sticky: a core result arrived with no outstanding tag
//
// Build option: define SYNTHESIJER_FCONV_ARB_RR_EN for round-robin arbitration;
// without it the lowest requesting index always wins and no pointer exists.

// Small tag FIFO. Tags of issued conversions wait here until the core hands
// back the matching result, which keeps results in issue order.
module synthesijer_fconv_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // Overflow/underflow requests are ignored rather than corrupting state.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end
endmodule

module synthesijer_fconv_i2f_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ*32-1:0]           req_a,
  input  logic [NUM_REQ-1:0]              req_nd,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [31:0]                     res_data,
  output logic [NUM_REQ-1:0]              res_valid,
  output logic [31:0]                     ip_a,
  output logic                            ip_nd,
  input  logic [31:0]                     ip_result,
  input  logic                            ip_valid,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err
);
  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (MAX_INFLIGHT < 2 || MAX_INFLIGHT > 32 ||
      (MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0) begin : g_bad_max_inflight
    $error("MAX_INFLIGHT must be a power of two in 2..32");
  end

  // Unpacked view of the operand bus, one word per port.
  logic [31:0] req_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_arr[g] = req_a[32*g +: 32];
  end

  logic             at_cap;
  logic             can_issue;
  logic             gnt_vld;
  logic [TAG_W-1:0] gnt_idx;
  logic             fifo_empty;
  logic             pop;
  logic [TAG_W-1:0] pop_tag;
  logic [NUM_REQ-1:0] pop_onehot;

  // The cap is judged on the registered count only: a result popping in the
  // same cycle does not open a slot until the next cycle.
  assign at_cap    = (inflight == CNT_W'(MAX_INFLIGHT));
  assign can_issue = !reset && !at_cap;

`ifdef SYNTHESIJER_FCONV_ARB_RR_EN
  // Round-robin: scan from rr_ptr upwards, wrapping at NUM_REQ.
  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W:0]   cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (can_issue) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (TAG_W+1)'(k);
        if (cand >= (TAG_W+1)'(NUM_REQ)) cand = cand - (TAG_W+1)'(NUM_REQ);
        if (!gnt_vld && req_nd[cand[TAG_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand[TAG_W-1:0];
        end
      end
    end
  end

  // After granting port i, port i+1 becomes the highest priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (gnt_vld) begin
      rr_ptr <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (can_issue) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_vld && req_nd[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = TAG_W'(k);
        end
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  // Registered issue: a grant is always a transfer, since only requesting
  // ports can be granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ip_nd <= 1'b0;
      ip_a  <= '0;
    end else begin
      ip_nd <= gnt_vld;
      if (gnt_vld) ip_a <= req_arr[gnt_idx];
    end
  end

  // The FIFO occupancy doubles as the outstanding-conversion counter.
  assign pop = ip_valid && !fifo_empty;

  synthesijer_fconv_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (gnt_vld),
    .push_dat (gnt_idx),
    .pop      (pop),
    .pop_dat  (pop_tag),
    .empty    (fifo_empty),
    .count    (inflight)
  );

  always_comb begin
    pop_onehot = '0;
    pop_onehot[pop_tag] = 1'b1;
  end

  // Result return: res_data holds its last value between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= pop ? pop_onehot : '0;
      if (pop) res_data <= ip_result;
    end
  end

  // A result with no tag to claim it is dropped and flagged until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (ip_valid && fifo_empty) begin
      err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_synthesijer_fconv_i2f_arbiter.sv
`timescale 1ns/1ps
module tb_synthesijer_fconv_i2f_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int MAX_INFLIGHT = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ-1:0]    req_nd;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           res_data;
  logic [NUM_REQ-1:0]    res_valid;
  logic [31:0]           ip_a;
  logic                  ip_nd;
  logic [31:0]           ip_result;
  logic                  ip_valid;
  logic [3:0]            inflight;
  logic                  err;

  always #5 clk = ~clk;

  synthesijer_fconv_i2f_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .req_nd    (req_nd),
    .req_ready (req_ready),
    .res_data  (res_data),
    .res_valid (res_valid),
    .ip_a      (ip_a),
    .ip_nd     (ip_nd),
    .ip_result (ip_result),
    .ip_valid  (ip_valid),
    .inflight  (inflight),
    .err       (err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference int -> float (exact for the small operands used here).
  function automatic logic [31:0] i2f(input logic [31:0] v);
    logic        s;
    logic [31:0] m;
    int          p;
    if (v == 32'd0) return 32'd0;
    s = v[31];
    m = s ? -v : v;
    p = 0;
    for (int b = 0; b < 32; b++) if (m[b]) p = b;
    if (p > 23) m = m >> (p - 23);
    else        m = m << (23 - p);
    return {s, 8'(127 + p), m[22:0]};
  endfunction

  // Fixed-latency converter core model, latency core_lat cycles from ip_nd.
  int          core_lat = 8;
  logic        core_clr = 1'b1;
  logic [31:0] pipe_d [64];
  logic        pipe_v [64];

  always @(posedge clk) begin
    if (core_clr) begin
      for (int i = 0; i < 64; i++) pipe_v[i] <= 1'b0;
    end else begin
      for (int i = 63; i > 0; i--) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      pipe_v[0] <= ip_nd;
      pipe_d[0] <= i2f(ip_a);
    end
  end

  assign ip_valid  = pipe_v[core_lat-1];
  assign ip_result = pipe_d[core_lat-1];

  // Scoreboard of expected results, in expected issue order.
  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    exp_t e;
    if (res_valid != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_res", 32'(res_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_tag", 32'(res_valid), 32'd1 << e.port);
        chk("res_data", res_data, e.data);
      end
    end
  end

  // Per-port operand value: changes only after that port is granted.
  int cnt [NUM_REQ];
  function automatic logic [31:0] val(input int p);
    return 32'(16 * p + cnt[p] + 1);
  endfunction

  task automatic set_a();
    for (int p = 0; p < NUM_REQ; p++) req_a[32*p +: 32] = val(p);
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic sample_edge();
    @(negedge clk);
  endtask

  task automatic grant_cycle(input logic [3:0] nd, input int exp_port);
    drive_edge();
    req_nd = nd;
    set_a();
    sample_edge();
    chk("req_ready", 32'(req_ready), (exp_port < 0) ? 32'd0 : (32'd1 << exp_port));
    if (exp_port >= 0) begin
      exp_q.push_back('{exp_port, i2f(val(exp_port))});
      cnt[exp_port]++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive_edge();
      req_nd = '0;
      sample_edge();
    end
  endtask

  task automatic do_reset();
    drive_edge();
    reset    = 1'b1;
    req_nd   = '0;
    core_clr = 1'b1;
    exp_q.delete();
    for (int p = 0; p < NUM_REQ; p++) cnt[p] = 0;
    set_a();
    sample_edge();
    drive_edge();
    sample_edge();
    drive_edge();
    reset    = 1'b0;
    core_clr = 1'b0;
    sample_edge();
  endtask

  int nd_tab  [8];
  int exp_tab [8];
  int cap_tab [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    req_nd = '0;
    req_a  = '0;
    for (int p = 0; p < NUM_REQ; p++) cnt[p] = 0;

    // Reset state: grants suppressed even with every port requesting.
    drive_edge();
    req_nd = 4'hF;
    set_a();
    sample_edge();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    drive_edge();
    sample_edge();
    chk("rst_req_ready2", 32'(req_ready), 32'd0);
    chk("rst_ip_nd", 32'(ip_nd), 32'd0);
    chk("rst_ip_a", ip_a, 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    do_reset();

    // Single port 0, a=5, latency 8.
    core_lat = 8;
    drive_edge();
    req_nd = 4'b0001;
    req_a[31:0] = 32'd5;
    sample_edge();
    chk("s1_ready", 32'(req_ready), 32'h1);
    exp_q.push_back('{0, 32'h40A00000});
    drive_edge();
    req_nd = '0;
    sample_edge();
    chk("s1_ip_nd", 32'(ip_nd), 32'd1);
    chk("s1_ip_a", ip_a, 32'd5);
    chk("s1_inflight", 32'(inflight), 32'd1);
    idle(1);
    chk("s1_ip_nd_once", 32'(ip_nd), 32'd0);
    idle(7);
    chk("s1_res_early", 32'(res_valid), 32'd0);
    idle(1);
    chk("s1_res_valid", 32'(res_valid), 32'h1);
    chk("s1_res_data", res_data, 32'h40A00000);
    idle(1);
    chk("s1_res_drop", 32'(res_valid), 32'd0);
    chk("s1_res_hold", res_data, 32'h40A00000);
    chk("s1_inflight_end", 32'(inflight), 32'd0);
    chk("s1_pending", 32'(exp_q.size()), 32'd0);

    // All ports requesting; port 0 drops out for the last two cycles.
    do_reset();
    nd_tab = '{15, 15, 15, 15, 15, 15, 14, 14};
`ifdef SYNTHESIJER_FCONV_ARB_RR_EN
    exp_tab = '{0, 1, 2, 3, 0, 1, 2, 3};
`else
    exp_tab = '{0, 0, 0, 0, 0, 0, 1, 1};
`endif
    for (int i = 0; i < 8; i++) grant_cycle(4'(nd_tab[i]), exp_tab[i]);
    idle(1);
    chk("s2_inflight_peak", 32'(inflight), 32'd8);
    idle(12);
    chk("s2_inflight_end", 32'(inflight), 32'd0);
    chk("s2_pending", 32'(exp_q.size()), 32'd0);

    // Cap: latency 20, continuous requests -> 8 grants then stall.
    do_reset();
    core_lat = 20;
`ifdef SYNTHESIJER_FCONV_ARB_RR_EN
    cap_tab = '{0, 1, 2, 3, 0, 1, 2, 3};
`else
    cap_tab = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 8; i++) grant_cycle(4'hF, cap_tab[i]);
    // Cycles 8..21; the first ip_valid lands in cycle 21 and must not open a slot yet.
    for (int i = 8; i < 22; i++) begin
      grant_cycle(4'hF, -1);
      chk("s4_inflight_full", 32'(inflight), 32'd8);
    end
    grant_cycle(4'hF, 0);
    chk("s4_inflight_after_pop", 32'(inflight), 32'd7);
    idle(1);
    chk("s4_inflight_pushpop", 32'(inflight), 32'd7);
    idle(23);
    chk("s4_inflight_end", 32'(inflight), 32'd0);
    chk("s4_pending", 32'(exp_q.size()), 32'd0);

    // Reset with 3 outstanding; stray results arrive after release.
    core_lat = 8;
    do_reset();
    for (int i = 0; i < 3; i++) grant_cycle(4'b0001, 0);
    idle(1);
    drive_edge();
    reset  = 1'b1;
    req_nd = 4'b0001;
    exp_q.delete();
    sample_edge();
    chk("s5_ready_in_reset", 32'(req_ready), 32'd0);
    drive_edge();
    sample_edge();
    chk("s5_inflight_reset", 32'(inflight), 32'd0);
    drive_edge();
    reset  = 1'b0;
    req_nd = '0;
    sample_edge();
    chk("s5_err_clear", 32'(err), 32'd0);
    idle(2);
    chk("s5_err_before_stray", 32'(err), 32'd0);
    idle(4);
    chk("s5_err_set", 32'(err), 32'd1);
    chk("s5_inflight_stray", 32'(inflight), 32'd0);
    chk("s5_res_valid_stray", 32'(res_valid), 32'd0);
    idle(3);
    chk("s5_err_sticky", 32'(err), 32'd1);
    do_reset();
    chk("s5_err_reset", 32'(err), 32'd0);

    // Push and pop in the same cycle at inflight=4.
    for (int i = 0; i < 4; i++) grant_cycle(4'(1 << i), i);
    idle(1);
    chk("s6_inflight4", 32'(inflight), 32'd4);
    idle(4);
    grant_cycle(4'b0010, 1);
    chk("s6_inflight_pre", 32'(inflight), 32'd4);
    idle(1);
    chk("s6_inflight_pushpop", 32'(inflight), 32'd4);
    idle(11);
    chk("s6_inflight_end", 32'(inflight), 32'd0);
    chk("s6_pending", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/synthesijer_fconv_i2f_arbiter.md
SYNTHESIJER_FCONV_I2F_ARBITER -- requirements
Module: synthesijer_fconv_i2f_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requester ports (2..8).
REQ-002 Parameter MAX_INFLIGHT, default 8, meaning tag FIFO depth and maximum outstanding conversions (power of two, 2..32).
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_a  input  NUM_REQ*32  signed int operands; port i occupies bits [32i+31:32i].
REQ-006 req_nd  input  NUM_REQ  request strobe per port.
REQ-007 req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_nd[i] and req_ready[i] are both high.
REQ-008 res_data  output  32  converted float result, shared by all ports.
REQ-009 res_valid  output  NUM_REQ  one-hot result strobe identifying the owning port.
REQ-010 ip_a  output  32  operand to the converter core.
REQ-011 ip_nd  output  1  operand valid to the converter core.
REQ-012 ip_result  input  32  converter core result.
REQ-013 ip_valid  input  1  converter core result valid; the core has fixed latency and no backpressure.
REQ-014 inflight  output  $clog2(MAX_INFLIGHT)+1  number of outstanding conversions.
REQ-015 err  output  1  sticky error flag.

Function
REQ-016 req_ready SHALL be combinational from req_nd, the arbitration pointer and inflight, with at most one bit high per cycle.
REQ-017 No grant SHALL be issued while inflight == MAX_INFLIGHT, even if ip_valid is high in the same cycle.
REQ-018 A requester SHALL hold req_nd and req_a stable until granted; the block SHALL NOT check this.
REQ-019 On a transfer from port i, ip_a SHALL equal req_a[i] and ip_nd SHALL be high on the next cycle only (1-cycle registered issue).
REQ-020 On each transfer, tag i SHALL be pushed into the tag FIFO, and inflight SHALL increment.
REQ-021 On ip_valid with a non-empty FIFO, the head tag t SHALL be popped, and inflight SHALL decrement.
REQ-022 On the next cycle, res_data SHALL equal ip_result and res_valid SHALL equal one-hot(t) for exactly one cycle.
REQ-023 A simultaneous push and pop SHALL leave inflight unchanged and preserve FIFO order.
REQ-024 On ip_valid with an empty FIFO, the result SHALL be discarded, res_valid SHALL stay 0, inflight SHALL stay 0 and err SHALL set.
REQ-025 err SHALL remain set until reset.
REQ-026 Results SHALL be returned in issue order; FIFO pointers SHALL wrap modulo MAX_INFLIGHT.
REQ-027 res_data SHALL hold its last value when res_valid is 0.
REQ-028 The block SHALL contain no state machine beyond the arbitration pointer, tag FIFO, inflight counter and err flag.

Reset
REQ-029 On reset: req_ready=0 for that cycle, ip_nd=0, ip_a=0, res_valid=0, res_data=0, inflight=0, err=0, pointer=0, and FIFO empty.
REQ-030 Reset during outstanding conversions SHALL drop all tags; core results arriving afterwards SHALL be handled per REQ-024.
REQ-031 Integration SHALL hold reset for at least the core latency to avoid such stray results.

Configuration
REQ-032 Macro SYNTHESIJER_FCONV_ARB_RR_EN selects the arbitration policy.
REQ-033 With the macro defined, arbitration SHALL be round-robin: after granting port i, the highest priority SHALL become (i+1) mod NUM_REQ.
REQ-034 Without the macro, arbitration SHALL be fixed priority with the lowest index winning, and the pointer logic SHALL be absent.

Verification
REQ-035 Bench SHALL cover these scenarios:
- Single port 0, a=5, core latency 8 -> ip_nd one cycle after grant; res_valid=0001 and res_data=0x40A00000 ten cycles after the transfer.
- Ports 0..3 all requesting continuously, RR_EN defined -> grants 0,1,2,3,0,... one per cycle; each result returns tagged to its issuer, in order.
- Same stimulus, RR_EN undefined -> port 0 granted every cycle until it drops req_nd; ports 1..3 starve.
- MAX_INFLIGHT=8, latency 20, continuous requests -> exactly 8 grants, then req_ready=0 until the first ip_valid; inflight peaks at 8, never 9.
- Reset asserted with 3 outstanding, stray ip_valid after release -> res_valid stays 0, err=1, inflight=0.
- Push and pop in the same cycle at inflight=4 -> inflight stays 4 and tag order is preserved.
